cmd_regfile_mc: RTL and testbench

Multi-channel successor to the single-channel LED command decoder. Takes host write and read strobes with an address, then passes them through a parametrised input delay pipeline. Decodes per-channel timing and LED-mode registers and presents each update to its LED channel over a valid/ready handshake. Returns readback data with a fixed latency and keeps per-channel sticky overrun status. Sits between the host command interface and NUM_CH LED timer/pattern channels.

---
 rtl/cmd_regfile_mc_pkg.sv | 27 ++
 rtl/cmd_regfile_mc_if.sv | 36 +++
 rtl/cmd_regfile_mc_slot.sv | 46 ++++
 rtl/cmd_regfile_mc.sv | 182 ++++++++++++++++++
 tb/tb_cmd_regfile_mc.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_regfile_mc_pkg.sv
// Shared constants for the multi-channel LED command register file.
package cmd_pkg;

    // Write-data field positions for the TIME and MODE registers
    localparam int TIME_NUM_MSB  = 15;
    localparam int TIME_NUM_LSB  = 8;
    localparam int TIME_UNIT_MSB = 7;
    localparam int TIME_UNIT_LSB = 4;
    localparam int MODE_MSB      = 3;
    localparam int MODE_LSB      = 0;

    // Slot widths: TIME holds {time_num, time_unit}, MODE holds led_mode
    localparam int TIME_W = TIME_NUM_MSB - TIME_UNIT_LSB + 1;
    localparam int MODE_W = MODE_MSB - MODE_LSB + 1;

    // Low address bit selects the register within a channel pair
    typedef enum logic {
        SEL_TIME = 1'b0,
        SEL_MODE = 1'b1
    } reg_sel_e;

    // STATUS sits directly after the last channel pair
    function automatic int status_addr(input int num_ch);
        return 2 * num_ch;
    endfunction

endpackage

// File: rtl/cmd_regfile_mc_if.sv
// Host command bus plus per-channel update handshakes.
interface cmd_regfile_mc_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [15:0]           wr_data;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_valid;
    logic [15:0]           rd_data;
    logic                  rd_err;
    logic                  wr_err;
    logic [NUM_CH-1:0]     time_valid;
    logic [NUM_CH-1:0]     time_ready;
    logic [NUM_CH*8-1:0]   time_num;
    logic [NUM_CH*4-1:0]   time_unit;
    logic [NUM_CH-1:0]     mode_valid;
    logic [NUM_CH-1:0]     mode_ready;
    logic [NUM_CH*4-1:0]   led_mode;

    // Host and LED channels together drive the inputs
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, time_ready, mode_ready,
        input  rd_valid, rd_data, rd_err, wr_err,
               time_valid, time_num, time_unit, mode_valid, led_mode
    );

    // The register file itself
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, time_ready, mode_ready,
        output rd_valid, rd_data, rd_err, wr_err,
               time_valid, time_num, time_unit, mode_valid, led_mode
    );
endinterface

// File: rtl/cmd_regfile_mc_slot.sv
// One configuration slot: holding register, valid/ready handshake and
// sticky overrun flag.
module cmd_cfg_slot #(
    parameter int           W       = 12,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    input  logic         ready,
    input  logic         ovr_clr,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovr
);

    // A load landing while the consumer is stalled is an overrun; a load in
    // the same cycle as the handshake simply queues the next value.
    logic stall_hit;
    assign stall_hit = ld && valid && !ready;

    // Data/valid update: load wins over handshake completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= RST_VAL;
            valid <= 1'b0;
        end else if (ld) begin
            data  <= ld_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun: a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovr <= 1'b0;
        else if (stall_hit)
            ovr <= 1'b1;
        else if (ovr_clr)
            ovr <= 1'b0;
    end

endmodule

// File: rtl/cmd_regfile_mc.sv
// Multi-channel LED command register file: delayed host strobes, decode
// into per-channel TIME/MODE slots, fixed-latency readback, W1C status.
module cmd_regfile_mc
    import cmd_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int TIME_NUM_RST = 3
) (
    input  logic             clk,
    input  logic             reset,
    cmd_regfile_mc_if.slave  bus
);

    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(status_addr(NUM_CH));
    localparam logic [TIME_W-1:0] TIME_RST  = TIME_W'((TIME_NUM_RST & 255) << 4);

    // Input delay line; the enable bits double as the pipeline valid shift
    logic [SYNC_STAGES-1:0]             wr_vld_pipe;
    logic [SYNC_STAGES-1:0]             rd_vld_pipe;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] wr_addr_pipe;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] rd_addr_pipe;
    logic [SYNC_STAGES-1:0][15:0]       wr_data_pipe;

    // Shift all host inputs through SYNC_STAGES registers; reset drops in-flight commands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_vld_pipe  <= '0;
            rd_vld_pipe  <= '0;
            wr_addr_pipe <= '0;
            rd_addr_pipe <= '0;
            wr_data_pipe <= '0;
        end else begin
            wr_vld_pipe[0]  <= bus.wr_en;
            rd_vld_pipe[0]  <= bus.rd_en;
            wr_addr_pipe[0] <= bus.wr_addr;
            rd_addr_pipe[0] <= bus.rd_addr;
            wr_data_pipe[0] <= bus.wr_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wr_vld_pipe[i]  <= wr_vld_pipe[i-1];
                rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
                wr_addr_pipe[i] <= wr_addr_pipe[i-1];
                rd_addr_pipe[i] <= rd_addr_pipe[i-1];
                wr_data_pipe[i] <= wr_data_pipe[i-1];
            end
        end
    end

    logic              wr_s, rd_s;
    logic [ADDR_W-1:0] wa, ra;
    logic [15:0]       wd;
    logic [31:0]       wd_ext;

    assign wr_s   = wr_vld_pipe[SYNC_STAGES-1];
    assign rd_s   = rd_vld_pipe[SYNC_STAGES-1];
    assign wa     = wr_addr_pipe[SYNC_STAGES-1];
    assign ra     = rd_addr_pipe[SYNC_STAGES-1];
    assign wd     = wr_data_pipe[SYNC_STAGES-1];
    assign wd_ext = {16'h0, wd};

    logic [NUM_CH-1:0][TIME_W-1:0] time_q;
    logic [NUM_CH-1:0][MODE_W-1:0] mode_q;
    logic [NUM_CH-1:0]             time_vld, mode_vld, time_ovr, mode_ovr;
    logic [NUM_CH-1:0]             time_ld, mode_ld, time_clr, mode_clr;
    logic                          wr_stat, wr_bad;

    // Write decode: full-width compare so no address aliases onto a register
    always_comb begin
        time_ld  = '0;
        mode_ld  = '0;
        time_clr = '0;
        mode_clr = '0;
        wr_stat  = 1'b0;
        wr_bad   = 1'b0;
        if (wr_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wa == ADDR_W'(2*c + int'(SEL_TIME))) time_ld[c] = 1'b1;
                if (wa == ADDR_W'(2*c + int'(SEL_MODE))) mode_ld[c] = 1'b1;
            end
            wr_stat = (wa == STAT_ADDR);
            wr_bad  = !wr_stat && (time_ld == '0) && (mode_ld == '0);
        end
        // Status bits above 15 are not reachable through the 16-bit bus
        for (int c = 0; c < NUM_CH; c++) begin
            time_clr[c] = wr_stat && wd_ext[2*c];
            mode_clr[c] = wr_stat && wd_ext[2*c+1];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cmd_cfg_slot #(.W(TIME_W), .RST_VAL(TIME_RST)) u_time (
            .clk     (clk),
            .reset   (reset),
            .ld      (time_ld[c]),
            .ld_data (wd[TIME_NUM_MSB:TIME_UNIT_LSB]),
            .ready   (bus.time_ready[c]),
            .ovr_clr (time_clr[c]),
            .valid   (time_vld[c]),
            .data    (time_q[c]),
            .ovr     (time_ovr[c])
        );
        cmd_cfg_slot #(.W(MODE_W), .RST_VAL('0)) u_mode (
            .clk     (clk),
            .reset   (reset),
            .ld      (mode_ld[c]),
            .ld_data (wd[MODE_MSB:MODE_LSB]),
            .ready   (bus.mode_ready[c]),
            .ovr_clr (mode_clr[c]),
            .valid   (mode_vld[c]),
            .data    (mode_q[c]),
            .ovr     (mode_ovr[c])
        );
    end

    logic [NUM_CH-1:0][7:0] tn;
    logic [NUM_CH-1:0][3:0] tu;
    logic [NUM_CH-1:0][3:0] lm;

    // Repack slot contents onto the flat per-channel output buses
    always_comb begin
        tn = '0;
        tu = '0;
        lm = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tn[c] = time_q[c][TIME_NUM_MSB-TIME_UNIT_LSB:TIME_NUM_LSB-TIME_UNIT_LSB];
            tu[c] = time_q[c][TIME_UNIT_MSB-TIME_UNIT_LSB:0];
            lm[c] = mode_q[c];
        end
    end

    assign bus.time_num   = tn;
    assign bus.time_unit  = tu;
    assign bus.led_mode   = lm;
    assign bus.time_valid = time_vld;
    assign bus.mode_valid = mode_vld;

    logic [31:0] status_full;
    logic [15:0] rdata;
    logic        rd_hit;

    // Read mux sees pre-write slot state, so a same-cycle write is not visible
    always_comb begin
        status_full = '0;
        rdata       = '0;
        rd_hit      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            status_full[2*c]   = time_ovr[c];
            status_full[2*c+1] = mode_ovr[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ra == ADDR_W'(2*c + int'(SEL_TIME))) begin
                rd_hit = 1'b1;
                rdata  = {time_q[c], 4'h0};
            end
            if (ra == ADDR_W'(2*c + int'(SEL_MODE))) begin
                rd_hit = 1'b1;
                rdata  = {12'h0, mode_q[c]};
            end
        end
        if (ra == STAT_ADDR) begin
            rd_hit = 1'b1;
            rdata  = status_full[15:0];
        end
    end

    // Registered read response and write-error pulse (the decode stage)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_err   <= 1'b0;
            bus.wr_err   <= 1'b0;
        end else begin
            bus.rd_valid <= rd_s;
            bus.rd_data  <= (rd_s && rd_hit) ? rdata : 16'h0;
            bus.rd_err   <= rd_s && !rd_hit;
            bus.wr_err   <= wr_bad;
        end
    end

endmodule

// File: tb/tb_cmd_regfile_mc.sv
// Scoreboard bench for cmd_regfile_mc: a SYNC_STAGES=2 instance for the
// functional sequence and a SYNC_STAGES=4 instance for latency.
module tb_cmd_regfile_mc;

    localparam int NCH   = 4;
    localparam int LAT_A = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   last_k = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      wr_q[$];

    cmd_regfile_mc_if #(.NUM_CH(NCH), .ADDR_W(32)) ia ();
    cmd_regfile_mc_if #(.NUM_CH(NCH), .ADDR_W(32)) ib ();

    cmd_regfile_mc #(.NUM_CH(NCH), .ADDR_W(32), .SYNC_STAGES(2), .TIME_NUM_RST(3)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ia.slave)
    );

    cmd_regfile_mc #(.NUM_CH(NCH), .ADDR_W(32), .SYNC_STAGES(4), .TIME_NUM_RST(3)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ib.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [15:0] d, input bit bad);
        @(negedge clk);
        last_k     = cyc;
        ia.wr_en   = 1'b1;
        ia.wr_addr = a;
        ia.wr_data = d;
        if (bad) wr_q.push_back(cyc + LAT_A);
        @(negedge clk);
        ia.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [15:0] d, input logic err);
        rd_exp_t e;
        @(negedge clk);
        ia.rd_en   = 1'b1;
        ia.rd_addr = a;
        e.cyc = cyc + LAT_A; e.data = d; e.err = err;
        rd_q.push_back(e);
        @(negedge clk);
        ia.rd_en   = 1'b0;
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [15:0] wdat, input logic [15:0] rexp);
        rd_exp_t e;
        @(negedge clk);
        last_k     = cyc;
        ia.wr_en   = 1'b1;
        ia.wr_addr = a;
        ia.wr_data = wdat;
        ia.rd_en   = 1'b1;
        ia.rd_addr = a;
        e.cyc = cyc + LAT_A; e.data = rexp; e.err = 1'b0;
        rd_q.push_back(e);
        @(negedge clk);
        ia.wr_en   = 1'b0;
        ia.rd_en   = 1'b0;
    endtask

    // Response monitor: pop expected reads and write errors as they appear
    always @(negedge clk) begin : mon
        rd_exp_t e;
        int      k;
        if (rst_n) begin
            if (ia.rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_data", {16'h0, ia.rd_data}, {16'h0, e.data});
                    chk("rd_err", {31'h0, ia.rd_err}, {31'h0, e.err});
                end
            end
            if (ia.wr_err) begin
                if (wr_q.size() == 0) chk("wr_err_unexpected", 32'd1, 32'd0);
                else begin
                    k = wr_q.pop_front();
                    chk("wr_err_cyc", cyc, k);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sn_tn, sn_lm;
        logic [3:0]  seen;
        int          k1, k2, kr;

        ia.wr_en = 0; ia.wr_addr = 0; ia.wr_data = 0; ia.rd_en = 0; ia.rd_addr = 0;
        ia.time_ready = '0; ia.mode_ready = '0;
        ib.wr_en = 0; ib.wr_addr = 0; ib.wr_data = 0; ib.rd_en = 0; ib.rd_addr = 0;
        ib.time_ready = '1; ib.mode_ready = '1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_time_num", ia.time_num, 32'h03030303);
        chk("rst_time_unit", {16'h0, ia.time_unit}, 32'h0);
        chk("rst_led_mode", {16'h0, ia.led_mode}, 32'h0);
        chk("rst_time_valid", {28'h0, ia.time_valid}, 32'h0);
        chk("rst_mode_valid", {28'h0, ia.mode_valid}, 32'h0);
        chk("rst_rd_valid", {31'h0, ia.rd_valid}, 32'h0);
        rd(32'd0, 16'h0300, 1'b0);

        // TIME write, consumer ready: one-cycle valid
        ia.time_ready = 4'b0110;
        wr(32'd2, 16'h0A50, 1'b0);
        k1 = last_k;
        wait_until(k1 + LAT_A - 1);
        chk("t1_valid_early", {31'h0, ia.time_valid[1]}, 32'd0);
        wait_until(k1 + LAT_A);
        chk("t1_num", {24'h0, ia.time_num[15:8]}, 32'h0A);
        chk("t1_unit", {28'h0, ia.time_unit[7:4]}, 32'h5);
        chk("t1_valid", {31'h0, ia.time_valid[1]}, 32'd1);
        wait_until(k1 + LAT_A + 1);
        chk("t1_valid_drop", {31'h0, ia.time_valid[1]}, 32'd0);
        chk("t1_num_hold", {24'h0, ia.time_num[15:8]}, 32'h0A);

        // MODE overrun while stalled, then W1C
        wr(32'd3, 16'h0007, 1'b0);
        k1 = last_k;
        wr(32'd3, 16'h0002, 1'b0);
        k2 = last_k;
        wait_until(k1 + LAT_A);
        chk("m1_mode", {28'h0, ia.led_mode[7:4]}, 32'h7);
        chk("m1_valid", {31'h0, ia.mode_valid[1]}, 32'd1);
        wait_until(k2 + LAT_A);
        chk("m2_mode", {28'h0, ia.led_mode[7:4]}, 32'h2);
        chk("m2_valid", {31'h0, ia.mode_valid[1]}, 32'd1);
        rd(32'd8, 16'h0008, 1'b0);
        wr(32'd8, 16'h0008, 1'b0);
        rd(32'd8, 16'h0000, 1'b0);
        wait_until(cyc + LAT_A + 1);
        chk("m_hold_valid", {31'h0, ia.mode_valid[1]}, 32'd1);
        chk("m_hold_mode", {28'h0, ia.led_mode[7:4]}, 32'h2);
        ia.mode_ready[1] = 1'b1;
        @(negedge clk);
        chk("m_valid_drop", {31'h0, ia.mode_valid[1]}, 32'd0);

        // Back-to-back TIME writes with ready high: no overrun
        wr(32'd4, 16'h1110, 1'b0);
        wr(32'd4, 16'h2220, 1'b0);
        k2 = last_k;
        wait_until(k2 + LAT_A);
        chk("t2_num", {24'h0, ia.time_num[23:16]}, 32'h22);
        chk("t2_unit", {28'h0, ia.time_unit[11:8]}, 32'h2);
        chk("t2_valid", {31'h0, ia.time_valid[2]}, 32'd1);
        wait_until(k2 + LAT_A + 1);
        chk("t2_valid_drop", {31'h0, ia.time_valid[2]}, 32'd0);
        rd(32'd8, 16'h0000, 1'b0);

        // Unmapped addresses, including a high alias of address 2
        wait_until(cyc + LAT_A + 1);
        sn_tn = ia.time_num;
        sn_lm = {16'h0, ia.led_mode};
        wr(32'd9, 16'hFFFF, 1'b1);
        wr(32'h8000_0002, 16'h5555, 1'b1);
        k1 = last_k;
        rd(32'd9, 16'h0000, 1'b1);
        rd(32'h8000_0002, 16'h0000, 1'b1);
        wait_until(k1 + LAT_A + 1);
        chk("bad_time_num", ia.time_num, sn_tn);
        chk("bad_led_mode", {16'h0, ia.led_mode}, sn_lm);
        chk("bad_time_valid", {28'h0, ia.time_valid}, 32'h0);
        chk("bad_mode_valid", {28'h0, ia.mode_valid}, 32'h0);

        // Same-cycle read and write returns the old value
        ia.mode_ready[0] = 1'b1;
        rdwr(32'd1, 16'h0004, 16'h0000);
        rd(32'd1, 16'h0004, 1'b0);
        wait_until(cyc + LAT_A + 2);
        chk("rw_mode0", {28'h0, ia.led_mode[3:0]}, 32'h4);

        // Reset with a write in flight
        ia.mode_ready = '0;
        wr(32'd5, 16'h0009, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("ar_time_num", ia.time_num, 32'h03030303);
        chk("ar_time_unit", {16'h0, ia.time_unit}, 32'h0);
        chk("ar_led_mode", {16'h0, ia.led_mode}, 32'h0);
        chk("ar_time_valid", {28'h0, ia.time_valid}, 32'h0);
        chk("ar_mode_valid", {28'h0, ia.mode_valid}, 32'h0);
        chk("ar_rd_valid", {31'h0, ia.rd_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | ia.mode_valid;
        end
        chk("ar_no_ghost_valid", {28'h0, seen}, 32'h0);
        chk("ar_led_mode_after", {16'h0, ia.led_mode}, 32'h0);

        // SYNC_STAGES=4 instance: latency is 5
        @(negedge clk);
        k1 = cyc;
        ib.wr_en = 1'b1; ib.wr_addr = 32'd0; ib.wr_data = 16'h1230;
        @(negedge clk);
        kr = cyc;
        ib.wr_en = 1'b0;
        ib.rd_en = 1'b1; ib.rd_addr = 32'd0;
        @(negedge clk);
        ib.rd_en = 1'b0;
        wait_until(k1 + 4);
        chk("b_valid_early", {31'h0, ib.time_valid[0]}, 32'd0);
        chk("b_num_early", {24'h0, ib.time_num[7:0]}, 32'h03);
        wait_until(k1 + 5);
        chk("b_valid", {31'h0, ib.time_valid[0]}, 32'd1);
        chk("b_num", {24'h0, ib.time_num[7:0]}, 32'h12);
        chk("b_unit", {28'h0, ib.time_unit[3:0]}, 32'h3);
        chk("b_rd_early", {31'h0, ib.rd_valid}, 32'd0);
        wait_until(kr + 5);
        chk("b_rd_valid", {31'h0, ib.rd_valid}, 32'd1);
        chk("b_rd_data", {16'h0, ib.rd_data}, 32'h1230);

        repeat (4) @(negedge clk);
        chk("rd_q_left", rd_q.size(), 32'd0);
        chk("wr_q_left", wr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
